// File: rtl/gpio_pio_v2_pkg.sv
// Shared constants for the GPIO PIO: register word addresses and edge-type encodings.
package gpio_pio_v2_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_DIR      = 3'd1,
    ADDR_IRQMASK  = 3'd2,
    ADDR_EDGECAP  = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLR   = 3'd5,
    ADDR_BLINKEN  = 3'd6,
    ADDR_BLINKDIV = 3'd7
  } reg_addr_e;

  typedef enum int {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-bit input synchroniser with a history flop and a single-cycle edge pulse.
module gpio_sync_edge
  import gpio_pio_v2_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_val;
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_pulse = ~sync_val & prev_q;
      EDGE_ANY:  edge_pulse = sync_val ^ prev_q;
      default:   edge_pulse = sync_val & ~prev_q;
    endcase
  end

endmodule

// File: rtl/gpio_pio_v2.sv
// Memory-mapped GPIO port: direction, atomic set/clear, edge capture with IRQ, and blink prescaler.
module gpio_pio_v2
  import gpio_pio_v2_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter logic [WIDTH-1:0] OUT_RESET       = '0,
  parameter logic [WIDTH-1:0] DIR_RESET       = '1,
  parameter int               EDGE_TYPE       = EDGE_RISE,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter logic [31:0]      BLINK_DIV_RESET = 32'd25_000_000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       s1_address,
  input  logic             s1_chipselect,
  input  logic             s1_write_n,
  input  logic [31:0]      s1_writedata,
  output logic [31:0]      s1_readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d, blinken_q, blinken_d, cap_clr;
  logic [31:0]      div_q, div_d, cnt_q, cnt_d, rdata_q, rdata_d;
  logic             phase_q, phase_d, irq_q, irq_d;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wd, sync_val, edge_pulse, data_rd;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .pin_i     (pio_in),
    .sync_val  (sync_val),
    .edge_pulse(edge_pulse)
  );

  assign wr_en   = s1_chipselect & ~s1_write_n;
  assign rd_en   = s1_chipselect & s1_write_n;
  assign wd      = s1_writedata[WIDTH-1:0];
  assign data_rd = (out_q & dir_q) | (sync_val & ~dir_q);

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    mask_d    = mask_q;
    blinken_d = blinken_q;
    div_d     = div_q;
    cap_clr   = '0;
    if (wr_en) begin
      case (s1_address)
        ADDR_DATA:     out_d     = wd;
        ADDR_DIR:      dir_d     = wd;
        ADDR_IRQMASK:  mask_d    = wd;
        ADDR_EDGECAP:  cap_clr   = wd;
        ADDR_OUTSET:   out_d     = out_q | wd;
        ADDR_OUTCLR:   out_d     = out_q & ~wd;
        ADDR_BLINKEN:  blinken_d = wd;
        ADDR_BLINKDIV: div_d     = s1_writedata;
        default:       ;
      endcase
    end
    // Set is ORed in after the clear so a coincident edge wins.
    cap_d = (cap_q & ~cap_clr) | (edge_pulse & ~dir_q);
    irq_d = |(cap_q & mask_q);
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && (s1_address == ADDR_BLINKDIV)) begin
      cnt_d   = s1_writedata;
      phase_d = 1'b1;
    end else if (div_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = div_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (s1_address)
        ADDR_DATA:     rdata_d = zext(data_rd);
        ADDR_DIR:      rdata_d = zext(dir_q);
        ADDR_IRQMASK:  rdata_d = zext(mask_q);
        ADDR_EDGECAP:  rdata_d = zext(cap_q);
        ADDR_BLINKEN:  rdata_d = zext(blinken_q);
        ADDR_BLINKDIV: rdata_d = div_q;
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q     <= OUT_RESET;
      dir_q     <= DIR_RESET;
      mask_q    <= '0;
      cap_q     <= '0;
      blinken_q <= '0;
      div_q     <= BLINK_DIV_RESET;
      cnt_q     <= BLINK_DIV_RESET;
      phase_q   <= 1'b1;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      blinken_q <= blinken_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pio_out     = out_q & (~blinken_q | {WIDTH{phase_q}});
  assign pio_oe      = dir_q;
  assign irq         = irq_q;
  assign s1_readdata = rdata_q;

endmodule

// File: tb/tb_gpio_pio_v2.sv
// Directed bench for gpio_pio_v2 (WIDTH=8, rising edges, 2-stage synchroniser).
module tb_gpio_pio_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr = '0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  pin = '0;
  logic [7:0]  pout, poe;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  gpio_pio_v2 #(
    .WIDTH(8),
    .EDGE_TYPE(0),
    .SYNC_STAGES(2)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .s1_address   (addr),
    .s1_chipselect(cs),
    .s1_write_n   (wn),
    .s1_writedata (wdata),
    .s1_readdata  (rdata),
    .pio_in       (pin),
    .pio_out      (pout),
    .pio_oe       (poe),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wn = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; wn = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
    d = rdata;
  endtask

  logic [31:0] rv;
  logic [7:0]  exp8;

  initial begin
    vt[0]  = '{1'b1, 3'd0, 32'h0000_000F, 32'h0,  8'h0F};
    vt[1]  = '{1'b1, 3'd4, 32'h0000_0030, 32'h0,  8'h3F};
    vt[2]  = '{1'b1, 3'd5, 32'h0000_0003, 32'h0,  8'h3C};
    vt[3]  = '{1'b0, 3'd0, 32'h0,         32'h3C, 8'h3C};
    vt[4]  = '{1'b0, 3'd4, 32'h0,         32'h0,  8'h3C};
    vt[5]  = '{1'b0, 3'd5, 32'h0,         32'h0,  8'h3C};
    vt[6]  = '{1'b1, 3'd0, 32'hFFFF_FF00, 32'h0,  8'h00};
    vt[7]  = '{1'b0, 3'd0, 32'h0,         32'h0,  8'h00};
    vt[8]  = '{1'b1, 3'd2, 32'hFFFF_FFA5, 32'h0,  8'h00};
    vt[9]  = '{1'b0, 3'd2, 32'h0,         32'hA5, 8'h00};
    vt[10] = '{1'b0, 3'd1, 32'h0,         32'hFF, 8'h00};
    vt[11] = '{1'b1, 3'd2, 32'h0,         32'h0,  8'h00};
    vt[12] = '{1'b0, 3'd2, 32'h0,         32'h0,  8'h00};
    vt[13] = '{1'b1, 3'd6, 32'h0000_01FF, 32'h0,  8'h00};
    vt[14] = '{1'b0, 3'd6, 32'h0,         32'hFF, 8'h00};
    vt[15] = '{1'b1, 3'd6, 32'h0,         32'h0,  8'h00};
    vt[16] = '{1'b0, 3'd3, 32'h0,         32'h0,  8'h00};
    vt[17] = '{1'b1, 3'd7, 32'h1234_5678, 32'h0,  8'h00};
    vt[18] = '{1'b0, 3'd7, 32'h0,         32'h1234_5678, 8'h00};

    // Reset defaults
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset pio_oe", 32'(poe), 32'hFF);
    chk("reset pio_out", 32'(pout), 32'h00);
    chk("reset irq", 32'(irq), 32'h0);
    chk("reset readdata", rdata, 32'h0);
    bus_rd(3'd7, rv); chk("reset BLINKDIV", rv, 32'd25_000_000);
    bus_rd(3'd4, rv); chk("read OUTSET after reset", rv, 32'h0);

    // Register table: back-to-back accesses, one per cycle
    for (int i = 0; i < 19; i++) begin
      cs = 1'b1; wn = ~vt[i].is_wr; addr = vt[i].a; wdata = vt[i].d;
      @(posedge clk); #1;
      cs = 1'b0; wn = 1'b1;
      chk($sformatf("vec%0d pio_out", i), 32'(pout), 32'(vt[i].exp_out));
      if (!vt[i].is_wr) chk($sformatf("vec%0d readdata", i), rdata, vt[i].exp_rd);
    end
    bus_wr(3'd7, 32'd25_000_000);
    chk("readdata held across write", rdata, 32'h1234_5678);

    // Edge capture and irq latency
    bus_wr(3'd1, 32'hF0);
    bus_wr(3'd2, 32'h01);
    chk("pio_oe after DIR write", 32'(poe), 32'hF0);
    pin[0] = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("irq low at K+2", 32'(irq), 32'h0);
    @(posedge clk); #1;
    chk("irq high at K+3", 32'(irq), 32'h1);
    bus_rd(3'd3, rv); chk("EDGECAP after rise", rv, 32'h01);
    bus_wr(3'd3, 32'h01);
    chk("irq one cycle after clear", 32'(irq), 32'h1);
    @(posedge clk); #1;
    chk("irq two cycles after clear", 32'(irq), 32'h0);

    pin[7] = 1'b1; repeat (4) @(posedge clk); #1;
    pin[7] = 1'b0; repeat (4) @(posedge clk); #1;
    bus_rd(3'd3, rv); chk("EDGECAP ignores output bit", rv, 32'h0);
    pin[0] = 1'b0; repeat (4) @(posedge clk); #1;
    bus_rd(3'd3, rv); chk("EDGECAP ignores falling", rv, 32'h0);
    chk("irq stays low", 32'(irq), 32'h0);

    // Set-wins collision on bit 1
    pin[1] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    bus_wr(3'd3, 32'h02);
    bus_rd(3'd3, rv); chk("set wins over clear", rv, 32'h02);
    bus_wr(3'd3, 32'h02);
    bus_rd(3'd3, rv); chk("plain clear", rv, 32'h00);
    bus_rd(3'd0, rv); chk("DATA mixes inputs", rv, 32'h02);

    // Blink: BLINKDIV=3 -> phase changes every 4 cycles
    bus_wr(3'd7, 32'd3);
    bus_wr(3'd6, 32'h01);
    bus_wr(3'd0, 32'h03);
    for (int j = 3; j <= 18; j++) begin
      @(posedge clk); #1;
      exp8 = (((j / 4) % 2) == 0) ? 8'h03 : 8'h02;
      chk($sformatf("blink cycle %0d", j), 32'(pout), 32'(exp8));
    end
    bus_wr(3'd7, 32'd0);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      chk($sformatf("blink off %0d", j), 32'(pout), 32'h03);
    end
    bus_rd(3'd7, rv); chk("BLINKDIV zero", rv, 32'h0);

    // Async reset in the middle of a blink
    bus_wr(3'd7, 32'd3);
    pin[0] = 1'b1;
    repeat (5) @(posedge clk); #1;
    bus_rd(3'd1, rv); chk("DIR before reset", rv, 32'hF0);
    chk("pio_out before reset", 32'(pout), 32'h02);
    chk("irq before reset", 32'(irq), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset pio_out", 32'(pout), 32'h00);
    chk("async reset pio_oe", 32'(poe), 32'hFF);
    chk("async reset irq", 32'(irq), 32'h0);
    chk("async reset readdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rd(3'd7, rv); chk("BLINKDIV after reset", rv, 32'd25_000_000);
    bus_rd(3'd3, rv); chk("EDGECAP after reset", rv, 32'h0);
    bus_rd(3'd6, rv); chk("BLINKEN after reset", rv, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
